// File: rtl/store_logic_gen.sv
// -----------------------------------------------------------------------------
// store_logic_gen
//
// Write-side counterpart of the BRAM fetch address generator. Result words
// arrive from the compute datapath on a valid/ready stream and are written
// into the shared BRAM one tile at a time. It uses the same region map as the
// fetch side (W/b/I/Q/K/V) and the same tile sizes (32 or 512 words). An
// internal tile pointer places consecutive tiles back-to-back. store_done
// tells the arbiter that a tile is complete.
//
// Ports
//   clk                 rising-edge clock
//   rst                 synchronous, active-high reset
//   start_store         pulse: begin storing the next tile (honoured in IDLE only)
//   reset_addr_counter  pulse: clear the tile pointer (any state; wins over
//                       the end-of-tile increment)
//   Offset_Control[2:0] region select, latched at start
//   Tiles_Control       tile size, latched at start: 1 = 32 words, 0 = 512 words
//   in_data/in_valid    result stream input
//   in_ready            high while a tile is being written
//   bram_addr/bram_wdata/bram_en/bram_we
//                       registered BRAM write port; a beat accepted in cycle k
//                       is written in cycle k+1
//   store_done          one-cycle pulse in the cycle of the final write of a tile
//   busy                block is not IDLE
//
// Build option
//   STORE_TRANSPOSE_EN  when defined, the K region (Offset_Control = 100) is
//                       written column-major:
//                       REGION_WORDS + tile_ptr + word_cnt*TRANSPOSE_STRIDE.
//                       When undefined, K uses the linear formula and the
//                       transpose multiplier is not built.
// -----------------------------------------------------------------------------
module store_logic_gen #(
  parameter int ADDR_WIDTH       = 16,
  parameter int DATA_WIDTH       = 256,
  parameter int ORIGINAL_COLUMNS = 768,
  parameter int ORIGINAL_ROWS    = 512,
  parameter int NUM_BITS         = 8,
  parameter int TRANSPOSE_STRIDE = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_store,
  input  logic                  reset_addr_counter,
  input  logic [2:0]            Offset_Control,
  input  logic                  Tiles_Control,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_wdata,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic                  store_done,
  output logic                  busy
);

  // Words occupied by one full matrix region (12288 at the defaults).
  localparam int REGION_WORDS = ORIGINAL_COLUMNS * ORIGINAL_ROWS * NUM_BITS / DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WRITING = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e                  state_q,    state_d;
  logic [8:0]              tile_ptr_q, tile_ptr_d;
  logic [9:0]              word_cnt_q, word_cnt_d;
  logic [2:0]              offset_q,   offset_d;
  logic                    tiles_q,    tiles_d;

  logic [ADDR_WIDTH-1:0]   addr_q,     addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q,    wdata_d;
  logic                    wr_q,       wr_d;

  logic                    beat_acc;
  logic                    last_word;
  logic [ADDR_WIDTH-1:0]   base_addr;
  logic [ADDR_WIDTH-1:0]   tile_off;
  logic [ADDR_WIDTH-1:0]   lin_addr;
  logic [ADDR_WIDTH-1:0]   beat_addr;

  // ---------------------------------------------------------------------------
  // Handshake and status decode
  // ---------------------------------------------------------------------------
  assign in_ready   = (state_q == S_WRITING);
  assign busy       = (state_q != S_IDLE);
  assign store_done = (state_q == S_DONE);
  assign beat_acc   = in_valid && in_ready;

  // The tile size comes from the latched control, not from the live input.
  assign last_word  = tiles_q ? (word_cnt_q == 10'd31) : (word_cnt_q == 10'd511);

  // ---------------------------------------------------------------------------
  // Beat address
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a value before any branch so that
    // no path leaves it unassigned; otherwise a latch would be inferred.
    base_addr = '0;
    unique case (offset_q)
      3'b001:  base_addr = ADDR_WIDTH'(64);
      3'b010:  base_addr = ADDR_WIDTH'(112);
      3'b100:  base_addr = ADDR_WIDTH'(REGION_WORDS);
      3'b101:  base_addr = ADDR_WIDTH'(2 * REGION_WORDS);
      default: base_addr = '0;  // W, Q and the unused codes all start at 0
    endcase

    // tile_ptr * WORDS as a shift: WORDS is 32 (<<5) or 512 (<<9).
    tile_off = tiles_q ? (ADDR_WIDTH'(tile_ptr_q) << 5)
                       : (ADDR_WIDTH'(tile_ptr_q) << 9);

    // Same-width sum truncates to ADDR_WIDTH naturally.
    lin_addr = base_addr + tile_off + ADDR_WIDTH'(word_cnt_q);

`ifdef STORE_TRANSPOSE_EN
    // K region, column-major: each beat steps one matrix row down, and the
    // tile pointer selects the column.
    if (offset_q == 3'b100) begin
      beat_addr = ADDR_WIDTH'(REGION_WORDS) + ADDR_WIDTH'(tile_ptr_q)
                + ADDR_WIDTH'(word_cnt_q) * ADDR_WIDTH'(TRANSPOSE_STRIDE);
    end else begin
      beat_addr = lin_addr;
    end
`else
    beat_addr = lin_addr;
`endif
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    tile_ptr_d = tile_ptr_q;
    word_cnt_d = word_cnt_q;
    offset_d   = offset_q;
    tiles_d    = tiles_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_store) begin
          state_d    = S_WRITING;
          word_cnt_d = '0;
          // Region and size are frozen for the whole tile.
          offset_d   = Offset_Control;
          tiles_d    = Tiles_Control;
        end
      end

      S_WRITING: begin
        if (beat_acc) begin
          word_cnt_d = word_cnt_q + 10'd1;
          if (last_word) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d    = S_IDLE;
        tile_ptr_d = tile_ptr_q + 9'd1;  // wraps 511 -> 0
      end

      default: state_d = S_IDLE;
    endcase

    // Pointer clear wins over the end-of-tile increment. A tile started in the
    // same cycle sees the cleared pointer, because its first beat comes later.
    if (reset_addr_counter) begin
      tile_ptr_d = '0;
    end
  end

  // Write port: the enables follow acceptance; address and data hold otherwise.
  always_comb begin
    wr_d    = beat_acc;
    addr_d  = beat_acc ? beat_addr : addr_q;
    wdata_d = beat_acc ? in_data   : wdata_q;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q    <= S_IDLE;
      tile_ptr_q <= '0;
      word_cnt_q <= '0;
      offset_q   <= '0;
      tiles_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      tile_ptr_q <= tile_ptr_d;
      word_cnt_q <= word_cnt_d;
      offset_q   <= offset_d;
      tiles_q    <= tiles_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
    end
  end

  assign bram_addr  = addr_q;
  assign bram_wdata = wdata_q;
  assign bram_en    = wr_q;
  assign bram_we    = wr_q;

endmodule
